mod5_frame_tx: RTL and testbench
================================

Name: mod5_frame_tx

Overview:
Serial transmitter for the mod-5 check stream. It takes a DATA_W-bit word and shifts it out MSB-first, one bit per clk. It then appends a 3-bit check suffix, also MSB-first, so the whole (DATA_W+3)-bit frame, read as an unsigned integer, is divisible by 5. It drives the single-bit serial line that the divide-by-five detector samples, so the detector reports remainder 0 after each intact frame.

Parameters:
DATA_W, 8, payload width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  frame request; sampled only when ready=1.
data_in  input  DATA_W  payload; captured on the accepted start cycle.
ready  output  1  registered; 1 = idle and able to accept start.
ser_out  output  1  registered serial bit, MSB-first.
ser_valid  output  1  registered; 1 while ser_out carries a frame bit.
frame_last  output  1  registered; 1 during the final check bit only.
done  output  1  registered; one-cycle pulse on the cycle after frame_last.
err_inject  input  1  present only with MOD5_ERR_INJECT_EN; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, ready=1, ser_out=0, ser_valid=0, frame_last=0, done=0, remainder=0, bit counter=0. Reset mid-frame aborts the frame immediately; the partial frame is not resumed.
- FSM states: IDLE, DATA, CHK.
- IDLE:
  - ser_out=0, ser_valid=0.
  - start=1 latches data_in into the shift register, clears the remainder, sets ready=0 and moves to DATA.
  - Latency: the first data bit (data_in[DATA_W-1]) appears on ser_out, with ser_valid=1, on the cycle after the accepting edge.
- DATA:
  - Emits DATA_W bits, MSB first.
  - Per bit b: rem <= (2*rem + b) mod 5; rem is 3 bits, range 0..4.
  - After the last data bit, the check value s = (2*rem_final) mod 5 is latched, and the FSM moves to CHK.
  - Derivation: the frame value is payload*8 + s, and 8 ≡ 3 (mod 5), so 3r + s ≡ 0 gives s ≡ 2r (mod 5).
- CHK:
  - Emits s[2], s[1], s[0] on three consecutive cycles; frame_last=1 with s[0].
  - Next cycle: IDLE, ready=1, ser_valid=0, ser_out=0, done=1 for exactly one cycle.
- Frame length and rate: frame length is DATA_W+3 cycles. The minimum start-to-start spacing is DATA_W+4 cycles, because one idle cycle is guaranteed between frames.
- start while ready=0 is ignored. It is not queued, and data_in changes during a frame have no effect.
- start asserted in the same cycle done=1: accepted, since ready=1 there.
- Idle line is 0. Leading zeros keep a remainder-0 accumulator at 0, so back-to-back frames with idle gaps leave a downstream mod-5 accumulator at 0 after every frame end, without a receiver reset.
- The bit counter is sized clog2(DATA_W+3) and wraps only through the FSM; no free-running wrap.

Optional Feature:
Macro MOD5_ERR_INJECT_EN.
- Defined:
  - Adds port err_inject, sampled together with an accepted start.
  - If err_inject was 1, s[0] is inverted for that frame only. The frame value changes by ±1, so it is guaranteed not divisible by 5.
  - This is a bench and field hook for checking the detector's failure path.
- Undefined: the port is absent and the check is always correct; no other difference.

Test Plan:
- Reset then start with data_in=8'd7 -> ser_out sequence 0000_0111_100 (frame value 60), frame_last on the 11th bit, done on the 12th cycle after acceptance, ready=1 again.
- data_in=8'd1 -> 0000_0001_010 (value 10); data_in=8'd3 -> 0000_0011_001 (value 25); data_in=8'd0 and 8'd255 -> check 000.
- Start pulses while ready=0 mid-frame with data_in=8'hAA -> ignored; frame continues unchanged; no extra frame follows.
- rst_n low at the 5th data bit of data 8'd7 -> next cycle ser_valid=0, ser_out=0, ready=1, no done; a new start for 8'd1 then yields a clean 0000_0001_010.
- Back-to-back frames 7, 3, 200 with start held high, driving the divide-by-five detector -> detector out=1 on the cycle after each frame_last. Accepts occur every DATA_W+4=12 cycles.
- With MOD5_ERR_INJECT_EN: data 8'd7 plus err_inject=1 -> check 101 (value 61), detector out=0 after the frame; the next frame without err_inject returns to a correct check.

Source files
------------

// File: rtl/mod5_frame_tx_if.sv
// Handshake and serial-line bundle for the mod-5 frame transmitter.
// err_inject exists only when MOD5_ERR_INJECT_EN is defined.
interface mod5_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_last;
    logic              done;
`ifdef MOD5_ERR_INJECT_EN
    logic              err_inject;

    modport master (
        output start, data_in, err_inject,
        input  ready, ser_out, ser_valid, frame_last, done
    );

    modport slave (
        input  start, data_in, err_inject,
        output ready, ser_out, ser_valid, frame_last, done
    );
`else
    modport master (
        output start, data_in,
        input  ready, ser_out, ser_valid, frame_last, done
    );

    modport slave (
        input  start, data_in,
        output ready, ser_out, ser_valid, frame_last, done
    );
`endif
endinterface

// File: rtl/mod5_frame_tx.sv
// Serial MSB-first transmitter appending a 3-bit suffix that makes each frame divisible by 5.
// Optional MOD5_ERR_INJECT_EN adds err_inject, which flips the last check bit of one frame.
module mod5_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mod5_frame_tx_if.slave    bus
);
    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CHK_MID   = CNT_W'(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CHK  = 2'd2
    } state_t;

    // One step of the remainder recurrence: (2*rem + b) mod 5, rem in 0..4.
    function automatic logic [2:0] mod5_step(input logic [2:0] rem, input logic b);
        logic [2:0] r;
        case ({rem, b})
            4'b000_0: r = 3'd0;
            4'b000_1: r = 3'd1;
            4'b001_0: r = 3'd2;
            4'b001_1: r = 3'd3;
            4'b010_0: r = 3'd4;
            4'b010_1: r = 3'd0;
            4'b011_0: r = 3'd1;
            4'b011_1: r = 3'd2;
            4'b100_0: r = 3'd3;
            4'b100_1: r = 3'd4;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        chk_q, chk_d;
    logic [2:0]        chk_s;
    logic              ready_q, ready_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              frame_last_q, frame_last_d;
    logic              done_q, done_d;
`ifdef MOD5_ERR_INJECT_EN
    logic              err_q, err_d;
`endif

    // Next-state and next-output logic for the IDLE/DATA/CHK sequencer.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        ready_d      = ready_q;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        frame_last_d = 1'b0;
        done_d       = 1'b0;
        // Suffix s = 2*r mod 5 cancels payload*8, since 8 = 3 (mod 5).
        chk_s        = mod5_step(rem_q, 1'b0);
`ifdef MOD5_ERR_INJECT_EN
        err_d        = err_q;
        chk_s        = {chk_s[2:1], chk_s[0] ^ err_q};
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // The MSB goes out on the accepting edge, so it is folded in here.
                    shift_d     = bus.data_in << 1;
                    ser_out_d   = bus.data_in[DATA_W-1];
                    ser_valid_d = 1'b1;
                    rem_d       = mod5_step(3'd0, bus.data_in[DATA_W-1]);
                    cnt_d       = CNT_W'(1);
                    ready_d     = 1'b0;
                    state_d     = S_DATA;
`ifdef MOD5_ERR_INJECT_EN
                    err_d       = bus.err_inject;
`endif
                end else begin
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                ser_valid_d = 1'b1;
                if (cnt_q == LAST_DATA) begin
                    ser_out_d = chk_s[2];
                    chk_d     = chk_s;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = S_CHK;
                end else begin
                    ser_out_d = shift_q[DATA_W-1];
                    shift_d   = shift_q << 1;
                    rem_d     = mod5_step(rem_q, shift_q[DATA_W-1]);
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_CHK: begin
                if (frame_last_q) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    rem_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CHK_MID) begin
                    ser_out_d   = chk_q[1];
                    ser_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end else begin
                    ser_out_d    = chk_q[0];
                    ser_valid_d  = 1'b1;
                    frame_last_d = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            rem_q        <= 3'd0;
            cnt_q        <= '0;
            chk_q        <= 3'd0;
            ready_q      <= 1'b1;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef MOD5_ERR_INJECT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            ready_q      <= ready_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
`ifdef MOD5_ERR_INJECT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign bus.ready      = ready_q;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.frame_last = frame_last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_mod5_frame_tx.sv
// Directed bench for mod5_frame_tx: table of payloads with hand-computed frames plus
// sequences for ignored starts, mid-frame reset, back-to-back frames and error injection.
module tb_mod5_frame_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mod5_frame_tx_if #(.DATA_W(8)) bus ();

    mod5_frame_tx #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference divide-by-five detector watching the serial line.
    logic [2:0] det_acc;
    always @(posedge clk) begin
        if (!rst_n) det_acc <= 3'd0;
        else        det_acc <= 3'((32'(det_acc) * 2 + 32'(bus.ser_out)) % 5);
    end

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic err, input logic [10:0] exp,
                             input bit poke, input string tag);
        logic [10:0] got;
        int          last_pos;
        bit          valid_ok;
        int          w;
        w = 0;
        while (!bus.ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready_before"}, 32'(bus.ready), 32'd1);
        bus.data_in = d;
        bus.start   = 1'b1;
`ifdef MOD5_ERR_INJECT_EN
        bus.err_inject = err;
`endif
        got = 11'd0;
        last_pos = -1;
        valid_ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, " ready_busy"}, 32'(bus.ready), 32'd0);
            got = {got[9:0], bus.ser_out};
            if (!bus.ser_valid || bus.done) valid_ok = 1'b0;
            if (bus.frame_last) begin
                if (last_pos != -1) valid_ok = 1'b0;
                last_pos = i;
            end
            bus.start = poke && (i >= 2) && (i <= 5);
            if (poke) bus.data_in = 8'hAA;
`ifdef MOD5_ERR_INJECT_EN
            bus.err_inject = 1'b0;
`endif
        end
        check({tag, " bits"}, 32'(got), 32'(exp));
        check({tag, " valid_run"}, 32'(valid_ok), 32'd1);
        check({tag, " last_pos"}, 32'(last_pos), 32'd10);
        @(negedge clk);
        check({tag, " done"}, {29'd0, bus.done, bus.ready, bus.ser_valid}, 32'b110);
        check({tag, " detector"}, 32'(det_acc == 3'd0), 32'((32'(exp) % 5) == 0));
        if (poke) begin
            valid_ok = 1'b1;
            for (int i = 0; i < 13; i++) begin
                @(negedge clk);
                if (bus.ser_valid || bus.done || !bus.ready) valid_ok = 1'b0;
            end
            check({tag, " no_extra_frame"}, 32'(valid_ok), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b2b_d [3];
        logic [10:0] b2b_f [3];
        logic [10:0] got;
        int          last_pos;

        vecs[0] = '{8'd7,   11'b00000111_100};
        vecs[1] = '{8'd1,   11'b00000001_010};
        vecs[2] = '{8'd3,   11'b00000011_001};
        vecs[3] = '{8'd0,   11'b00000000_000};
        vecs[4] = '{8'd255, 11'b11111111_000};
        vecs[5] = '{8'd2,   11'b00000010_100};
        vecs[6] = '{8'd4,   11'b00000100_011};
        vecs[7] = '{8'd9,   11'b00001001_011};
        vecs[8] = '{8'd128, 11'b10000000_001};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.data_in = 8'd0;
`ifdef MOD5_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state",
              {27'd0, bus.ready, bus.ser_out, bus.ser_valid, bus.frame_last, bus.done},
              32'b10000);

        for (int v = 0; v < 9; v++)
            run_frame(vecs[v].data, 1'b0, vecs[v].frame, 1'b0, $sformatf("vec%0d", v));

        run_frame(8'd7, 1'b0, 11'b00000111_100, 1'b1, "ignored_start");

        // Reset on the 5th data bit aborts the frame.
        bus.data_in = 8'd7;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("abort_mid_valid", 32'(bus.ser_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", {28'd0, bus.ready, bus.ser_out, bus.ser_valid, bus.done}, 32'b1000);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", {30'd0, bus.ser_valid, bus.done}, 32'd0);
        run_frame(8'd1, 1'b0, 11'b00000001_010, 1'b0, "after_abort");

        // Back-to-back with start held high: a new frame every 12 cycles.
        b2b_d[0] = 8'd7;   b2b_f[0] = 11'b00000111_100;
        b2b_d[1] = 8'd3;   b2b_f[1] = 11'b00000011_001;
        b2b_d[2] = 8'd200; b2b_f[2] = 11'b11001000_000;
        bus.data_in = b2b_d[0];
        bus.start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            got = 11'd0;
            last_pos = -1;
            for (int j = 1; j <= 12; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    check($sformatf("b2b%0d first_valid", f),
                          {30'd0, bus.ser_valid, bus.ready}, 32'b10);
                    if (f < 2) bus.data_in = b2b_d[f + 1];
                    else       bus.start = 1'b0;
                end
                if (j <= 11) begin
                    got = {got[9:0], bus.ser_out};
                    if (bus.frame_last) last_pos = j;
                end else begin
                    check($sformatf("b2b%0d done", f),
                          {29'd0, bus.done, bus.ready, bus.ser_valid}, 32'b110);
                    check($sformatf("b2b%0d detector", f), 32'(det_acc), 32'd0);
                end
            end
            check($sformatf("b2b%0d bits", f), 32'(got), 32'(b2b_f[f]));
            check($sformatf("b2b%0d last_pos", f), 32'(last_pos), 32'd11);
        end
        @(negedge clk);
        check("b2b_idle_after", {30'd0, bus.ser_valid, bus.ready}, 32'b01);

`ifdef MOD5_ERR_INJECT_EN
        run_frame(8'd7, 1'b1, 11'b00000111_101, 1'b0, "err_inject");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(8'd7, 1'b0, 11'b00000111_100, 1'b0, "err_cleared");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
